// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, default queue depth and the NOP encoding.
package pipeline_pkg;
  localparam int unsigned W             = 32;
  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam logic [31:0] NOP           = 32'b0;
endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries of {inst, pc}, two write ports, two async read ports, no reset.
module fetch_queue_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 64
) (
  input  logic                     clk,
  input  logic                     i_we0,
  input  logic [$clog2(DEPTH)-1:0] i_waddr0,
  input  logic [DW-1:0]            i_wdata0,
  input  logic                     i_we1,
  input  logic [$clog2(DEPTH)-1:0] i_waddr1,
  input  logic [DW-1:0]            i_wdata1,
  input  logic [$clog2(DEPTH)-1:0] i_raddr0,
  output logic [DW-1:0]            o_rdata0,
  input  logic [$clog2(DEPTH)-1:0] i_raddr1,
  output logic [DW-1:0]            o_rdata1
);
  logic [DW-1:0] r_mem [DEPTH];

  // Write addresses are always distinct (tail and tail+1), so the two ports never collide.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: accepts up to two fetched instructions per cycle, presents the oldest two.
// Optional FETCH_QUEUE_STATS_EN adds stat_issued / stat_split counters.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = pipeline_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         fetch_valid_0,
  input  logic [W-1:0] fetch_inst_0,
  input  logic [W-1:0] fetch_pc_0,
  input  logic         fetch_valid_1,
  input  logic [W-1:0] fetch_inst_1,
  input  logic [W-1:0] fetch_pc_1,
  output logic         fetch_ready,
  output logic [W-1:0] inst_0,
  output logic [W-1:0] PC_0,
  output logic [W-1:0] inst_1,
  output logic [W-1:0] PC_1,
  output logic         valid_0,
  output logic         valid_1,
  input  logic         issue_stall,
  input  logic         Way_0_busy
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]  stat_issued,
  output logic [31:0]  stat_split
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [AW:0]    r_count;
  logic           w_ready;
  logic           w_push0;
  logic           w_push1;
  logic [1:0]     w_npush;
  logic [1:0]     w_npop;
  logic [2*W-1:0] w_rd0;
  logic [2*W-1:0] w_rd1;

  // Readiness looks at the registered count only, never at same-cycle pops.
  assign w_ready = (r_count <= (AW+1)'(DEPTH - 2));
  assign w_push0 = w_ready & fetch_valid_0 & ~flush;
  assign w_push1 = w_push0 & fetch_valid_1;
  assign w_npush = {1'b0, w_push0} + {1'b0, w_push1};

  always_comb begin
    w_npop = 2'd0;
    if (!issue_stall && r_count != '0) begin
      if (Way_0_busy || r_count == (AW+1)'(1)) w_npop = 2'd1;
      else                                     w_npop = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_npop);
      r_tail  <= r_tail + AW'(w_npush);
      r_count <= r_count + (AW+1)'(w_npush) - (AW+1)'(w_npop);
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .DW    (2 * W)
  ) u_mem (
    .clk      (clk),
    .i_we0    (w_push0),
    .i_waddr0 (r_tail),
    .i_wdata0 ({fetch_inst_0, fetch_pc_0}),
    .i_we1    (w_push1),
    .i_waddr1 (r_tail + AW'(1)),
    .i_wdata1 ({fetch_inst_1, fetch_pc_1}),
    .i_raddr0 (r_head),
    .o_rdata0 (w_rd0),
    .i_raddr1 (r_head + AW'(1)),
    .o_rdata1 (w_rd1)
  );

  assign fetch_ready = w_ready;
  assign valid_0     = (r_count != '0);
  assign valid_1     = (r_count >= (AW+1)'(2));
  assign inst_0      = valid_0 ? w_rd0[2*W-1:W] : W'(NOP);
  assign PC_0        = valid_0 ? w_rd0[W-1:0]   : W'(NOP);
  assign inst_1      = valid_1 ? w_rd1[2*W-1:W] : W'(NOP);
  assign PC_1        = valid_1 ? w_rd1[W-1:0]   : W'(NOP);

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_split;

  // Flush cancels the pop, so nothing is counted that cycle; counters survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued <= '0;
      r_stat_split  <= '0;
    end else if (!flush) begin
      r_stat_issued <= r_stat_issued + 32'(w_npop);
      if (w_npop == 2'd1 && Way_0_busy) r_stat_split <= r_stat_split + 32'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_split  = r_stat_split;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences, random vs queue model.
module tb_fetch_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid_0 = 1'b0, fetch_valid_1 = 1'b0;
  logic [31:0] fetch_inst_0 = '0, fetch_pc_0 = '0, fetch_inst_1 = '0, fetch_pc_1 = '0;
  logic        fetch_ready;
  logic [31:0] inst_0, PC_0, inst_1, PC_1;
  logic        valid_0, valid_1;
  logic        issue_stall = 1'b0, Way_0_busy = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_issued, stat_split;
`endif

  fetch_queue #(.DEPTH(DEPTH), .W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid_0(fetch_valid_0), .fetch_inst_0(fetch_inst_0), .fetch_pc_0(fetch_pc_0),
    .fetch_valid_1(fetch_valid_1), .fetch_inst_1(fetch_inst_1), .fetch_pc_1(fetch_pc_1),
    .fetch_ready(fetch_ready), .inst_0(inst_0), .PC_0(PC_0), .inst_1(inst_1), .PC_1(PC_1),
    .valid_0(valid_0), .valid_1(valid_1), .issue_stall(issue_stall), .Way_0_busy(Way_0_busy)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_issued(stat_issued), .stat_split(stat_split)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t q[$];
  int unsigned m_issued, m_split;
  logic [31:0] pcn;
  int unsigned n_total = 0, n_pass = 0;

  typedef struct {
    bit fl, f0, f1, st, bz;
    bit ev0, ev1, erdy;
    logic [31:0] epc0, epc1;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_model();
    bit e0, e1;
    e0 = (q.size() >= 1);
    e1 = (q.size() >= 2);
    chk("valid_0", valid_0, e0);
    chk("valid_1", valid_1, e1);
    chk("fetch_ready", fetch_ready, q.size() <= DEPTH - 2);
    chk("inst_0", inst_0, e0 ? q[0].inst : 32'h0);
    chk("PC_0", PC_0, e0 ? q[0].pc : 32'h0);
    chk("inst_1", inst_1, e1 ? q[1].inst : 32'h0);
    chk("PC_1", PC_1, e1 ? q[1].pc : 32'h0);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks outputs.
  task automatic step(input bit fl, f0, f1, st, bz,
                      input logic [31:0] i0, p0, i1, p1, output int unsigned npush);
    int unsigned np;
    bit rdy;
    flush = fl; fetch_valid_0 = f0; fetch_valid_1 = f1; issue_stall = st; Way_0_busy = bz;
    fetch_inst_0 = i0; fetch_pc_0 = p0; fetch_inst_1 = i1; fetch_pc_1 = p1;
    rdy   = (q.size() <= DEPTH - 2);
    npush = (rdy && f0 && !fl) ? (f1 ? 2 : 1) : 0;
    if (st || q.size() == 0) np = 0;
    else if (bz || q.size() == 1) np = 1;
    else np = 2;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      for (int k = 0; k < int'(np); k++) begin q.delete(0); m_issued++; end
      if (np == 1 && bz) m_split++;
      if (npush >= 1) q.push_back('{i0, p0});
      if (npush == 2) q.push_back('{i1, p1});
    end
    #1;
    check_model();
  endtask

  task automatic stepg(input bit fl, f0, f1, st, bz);
    int unsigned n;
    step(fl, f0, f1, st, bz, ~pcn, pcn, ~(pcn + 32'd4), pcn + 32'd4, n);
    pcn = pcn + 32'(4 * n);
  endtask

  task automatic idle_inputs();
    flush = 0; fetch_valid_0 = 0; fetch_valid_1 = 0; issue_stall = 0; Way_0_busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete(); m_issued = 0; m_split = 0; pcn = '0;
    #1;
    chk("rst_valid_0", valid_0, 1'b0);
    chk("rst_ready", fetch_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n;
    tbl[0]  = '{0,1,1,1,0, 1,1,1, 32'h00, 32'h04};
    tbl[1]  = '{0,1,1,0,1, 1,1,1, 32'h04, 32'h08};
    tbl[2]  = '{0,1,0,0,0, 1,1,1, 32'h0C, 32'h10};
    tbl[3]  = '{0,0,0,0,1, 1,0,1, 32'h10, 32'h00};
    tbl[4]  = '{0,0,0,0,0, 0,0,1, 32'h00, 32'h00};
    tbl[5]  = '{0,0,1,0,0, 0,0,1, 32'h00, 32'h00};
    tbl[6]  = '{0,0,0,0,1, 0,0,1, 32'h00, 32'h00};
    tbl[7]  = '{0,1,1,1,0, 1,1,1, 32'h14, 32'h18};
    tbl[8]  = '{0,1,1,1,0, 1,1,1, 32'h14, 32'h18};
    tbl[9]  = '{0,1,1,1,0, 1,1,1, 32'h14, 32'h18};
    tbl[10] = '{0,1,1,1,0, 1,1,0, 32'h14, 32'h18};
    tbl[11] = '{0,1,1,1,0, 1,1,0, 32'h14, 32'h18};
    tbl[12] = '{1,1,1,1,0, 0,0,1, 32'h00, 32'h00};
    tbl[13] = '{0,1,1,0,0, 1,1,1, 32'h34, 32'h38};

    #2;
    chk("por_valid_1", valid_1, 1'b0);
    chk("por_PC_0", PC_0, 32'h0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      stepg(tbl[i].fl, tbl[i].f0, tbl[i].f1, tbl[i].st, tbl[i].bz);
      chk($sformatf("tbl%0d_v0", i), valid_0, tbl[i].ev0);
      chk($sformatf("tbl%0d_v1", i), valid_1, tbl[i].ev1);
      chk($sformatf("tbl%0d_rdy", i), fetch_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d_pc0", i), PC_0, tbl[i].epc0);
      chk($sformatf("tbl%0d_pc1", i), PC_1, tbl[i].epc1);
    end

    // Reset pair push
    do_reset();
    step(0, 1, 1, 0, 0, 32'h8C010000, 32'h0, 32'h00221820, 32'h4, n);
    chk("pair_v0", valid_0, 1'b1);
    chk("pair_v1", valid_1, 1'b1);
    chk("pair_inst0", inst_0, 32'h8C010000);
    chk("pair_PC1", PC_1, 32'h4);

    // Split issue: two LWs plus a third entry, slot 0 accepted only
    do_reset();
    step(0, 1, 1, 1, 0, 32'h8C010000, 32'h0, 32'h8C220004, 32'h4, n);
    step(0, 1, 0, 1, 0, 32'h00221820, 32'h8, 32'h0, 32'h0, n);
    step(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, n);
    chk("split_inst0", inst_0, 32'h8C220004);
    chk("split_v1", valid_1, 1'b1);
    chk("split_PC1", PC_1, 32'h8);

    // Fill to 7 then drain without loss
    do_reset();
    stepg(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) stepg(0, 1, 1, 1, 0);
    chk("fill7_ready", fetch_ready, 1'b0);
    stepg(0, 1, 1, 1, 0);
    chk("fill7_hold_ready", fetch_ready, 1'b0);
    chk("fill7_head", PC_0, 32'h0);
    for (int i = 0; i < 4; i++) stepg(0, 0, 0, 0, 0);
    chk("fill7_empty", valid_0, 1'b0);

    // Flush with 6 held and a simultaneous push
    do_reset();
    for (int i = 0; i < 3; i++) stepg(0, 1, 1, 1, 0);
    stepg(1, 1, 1, 0, 0);
    chk("flush_v0", valid_0, 1'b0);
    chk("flush_ready", fetch_ready, 1'b1);
    stepg(0, 0, 0, 0, 0);
    chk("flush_stays_empty", valid_0, 1'b0);

    // Steady 2-in/2-out across pointer wrap
    do_reset();
    stepg(0, 1, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      stepg(0, 1, 1, 0, 0);
      chk($sformatf("stream%0d_pc0", k), PC_0, 32'(8 * k));
      chk($sformatf("stream%0d_cnt2", k), {valid_1, fetch_ready}, 2'b11);
    end

    // Statistics: 3 split pops and 4 dual pops
    do_reset();
    stepg(0, 1, 0, 1, 0);
    stepg(0, 1, 1, 1, 0);
    stepg(0, 1, 1, 1, 0);
    stepg(0, 1, 1, 0, 1);
    stepg(0, 1, 1, 0, 1);
    stepg(0, 0, 0, 0, 1);
    stepg(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) stepg(0, 0, 0, 0, 0);
    chk("stats_drained", valid_0, 1'b0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("stat_split", stat_split, 32'd3);
    chk("stat_issued", stat_issued, 32'd11);
`endif

    // Reset asserted mid-push drops the pair
    idle_inputs();
    fetch_valid_0 = 1; fetch_valid_1 = 1; fetch_pc_0 = 32'h100; fetch_pc_1 = 32'h104;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_v0", valid_0, 1'b0);
    chk("midrst_ready", fetch_ready, 1'b1);
    chk("midrst_inst0", inst_0, 32'h0);
    q.delete(); m_issued = 0; m_split = 0; pcn = '0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_after_v0", valid_0, 1'b0);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      stepg($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end
`ifdef FETCH_QUEUE_STATS_EN
    chk("rand_stat_issued", stat_issued, 32'(m_issued));
    chk("rand_stat_split", stat_split, 32'(m_split));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, >= 4.
REQ-002 Parameter W, default 32, instruction and PC width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 flush  in  1  redirect; discards all queued entries.
REQ-006 fetch_valid_0, fetch_valid_1  in  1 each  fetch slot valids; slot 1 is older-after-slot-0.
REQ-007 fetch_inst_0, fetch_pc_0, fetch_inst_1, fetch_pc_1  in  W each  fetched pair.
REQ-008 fetch_ready  out  1  high when free entries >= 2.
REQ-009 inst_0, PC_0, inst_1, PC_1  out  W each  oldest two entries presented to the issue stage.
REQ-010 valid_0, valid_1  out  1 each  slot validity (valid_1 implies valid_0).
REQ-011 issue_stall  in  1  downstream stall; nothing consumed.
REQ-012 Way_0_busy  in  1  issue stage accepted only slot 0 this cycle.

Function
REQ-013 Push SHALL occur when fetch_ready & fetch_valid_0 & !flush; writes 1 entry, or 2 if fetch_valid_1.
REQ-014 fetch_valid_1 without fetch_valid_0 SHALL push nothing.
REQ-015 Outputs SHALL be combinational from head and head+1; invalid slot drives inst and PC to 0 (NOP).
REQ-016 Pop count SHALL be: 0 if issue_stall or count=0; 1 if Way_0_busy or count=1; else 2.
REQ-017 On Way_0_busy, the unconsumed slot-1 entry SHALL appear as inst_0/PC_0 next cycle, order preserved.
REQ-018 Push-to-visible latency SHALL be 1 cycle; no empty bypass.
REQ-019 Simultaneous push and pop SHALL both take effect; count_next = count + pushed - popped.
REQ-020 fetch_ready SHALL be computed from current count only, not from same-cycle pops.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-022 Full (count=DEPTH) or count=DEPTH-1 SHALL deassert fetch_ready; no overwrite ever.
REQ-023 flush SHALL override push and pop: next cycle count=0, pointers=0, valid_0=valid_1=0.
REQ-024 Empty queue SHALL ignore Way_0_busy and pop nothing.

Reset
REQ-025 rst_n low SHALL immediately clear pointers and count; valid_0=valid_1=0, inst/PC outputs 0, fetch_ready=1.
REQ-026 Storage array contents SHALL NOT require reset; outputs are masked by valid.
REQ-027 Reset asserted mid-push SHALL drop the in-flight pair.

Configuration
REQ-028 Macro FETCH_QUEUE_STATS_EN SHALL, when defined, add outputs stat_issued (32, instructions popped) and stat_split (32, cycles with Way_0_busy popping 1), both wrapping, cleared by rst_n and not by flush.
REQ-029 Without FETCH_QUEUE_STATS_EN, those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold W, the default DEPTH, and the NOP constant (32'b0).
REQ-031 Storage SHALL be a sub-module fetch_queue_mem: DEPTH x 2W, two write ports, two async read ports, no reset.
REQ-032 Pointer, count, and pop/push control SHALL reside in fetch_queue.

Verification
REQ-033 Reset, push pair (0x8C010000@0x00, 0x00221820@0x04) -> next cycle valid_0=valid_1=1, PC_0=0x00, PC_1=0x04.
REQ-034 Two LW entries queued, Way_0_busy=1 -> next cycle inst_0=second LW, valid_1 reflects the third entry, count decremented by 1.
REQ-035 Push 2/cycle, issue_stall=1, DEPTH=8 -> fetch_ready low at count=7 and 8; no entry lost or duplicated after release.
REQ-036 Queue holding 6, flush with simultaneous push -> next cycle valid_0=0, count=0, fetch_ready=1.
REQ-037 Push and pop 2/cycle for 20 cycles -> PC stream 0x00,0x04,... exact across pointer wrap, count constant.
REQ-038 With FETCH_QUEUE_STATS_EN, 3 busy-split cycles + 4 dual pops -> stat_split=3, stat_issued=11.
